// File: rtl/dac_frame_tx_if.sv
// Sample-strobe and serial DAC pins between the datapath and the frame serializer.
// master = sample source / pin observer, slave = dac_frame_tx.
interface dac_frame_tx_if #(
  parameter int N = 23
);
  logic                start;
  logic signed [N-1:0] data_in;
  logic                busy;
  logic                done;
  logic                sat;
  logic                sclk;
  logic                sync_n;
  logic                sdata;

  modport master (
    output start, data_in,
    input  busy, done, sat, sclk, sync_n, sdata
  );

  modport slave (
    input  start, data_in,
    output busy, done, sat, sclk, sync_n, sdata
  );
endinterface

// File: rtl/dac_frame_tx.sv
// Purpose: saturate a signed sample to 12-bit offset binary and shift it out as a 16-bit SPI frame.
// Latency: sync_n low one cycle after accept, for 32*CLK_DIV cycles; done pulse on the following cycle.
// Backpressure: start is honoured only in IDLE; strobes while busy are dropped, never queued.
module dac_frame_tx #(
  parameter int N       = 23,
  parameter int SHIFT   = 0,
  parameter int CLK_DIV = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  dac_frame_tx_if.slave bus
);

  localparam int             CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0]  HC_LAST = CW'(CLK_DIV - 1);
  localparam logic signed [N-1:0] C_MAX = N'(2047);
  localparam logic signed [N-1:0] C_MIN = N'(-2048);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  hcnt_q, hcnt_d;
  logic [3:0]     bcnt_q, bcnt_d;
  logic [15:0]    sh_q, sh_d;
  logic           sclk_q, sclk_d;
  logic           sat_q, sat_d;

  logic signed [N-1:0] v;
  logic signed [N-1:0] c;
  logic                sat_c;
  logic [11:0]         code;
  logic [15:0]         word;

  assign v = $signed(bus.data_in) >>> SHIFT;

  always_comb begin
    c     = v;
    sat_c = 1'b0;
    if (v > C_MAX) begin
      c     = C_MAX;
      sat_c = 1'b1;
    end else if (v < C_MIN) begin
      c     = C_MIN;
      sat_c = 1'b1;
    end
  end

  // Adding 2048 to a 12-bit two's complement value is just an MSB flip.
  assign code = {~c[11], c[10:0]};
  assign word = {4'b0000, code};

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    sclk_d  = sclk_q;
    sat_d   = sat_q;
    case (state_q)
      S_IDLE: begin
        sclk_d = 1'b1;
        if (bus.start) begin
          state_d = S_SHIFT;
          sh_d    = word;
          sat_d   = sat_c;
          hcnt_d  = '0;
          bcnt_d  = 4'd15;
        end
      end
      S_SHIFT: begin
        if (hcnt_q == HC_LAST) begin
          hcnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else begin
            // End of a low phase: next bit goes out with the rising edge.
            // The last shift empties the register so sdata idles at 0.
            sclk_d = 1'b1;
            sh_d   = {sh_q[14:0], 1'b0};
            if (bcnt_q == 4'd0) begin
              state_d = S_DONE;
            end else begin
              bcnt_d = bcnt_q - 4'd1;
            end
          end
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      S_DONE: begin
        sclk_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        sclk_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      hcnt_q  <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      sclk_q  <= 1'b1;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      sclk_q  <= sclk_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = (state_q == S_DONE);
  assign bus.sync_n = (state_q != S_SHIFT);
  assign bus.sclk   = sclk_q;
  assign bus.sdata  = sh_q[15];
  assign bus.sat    = sat_q;

endmodule

// File: tb/tb_dac_frame_tx.sv
// Bench for dac_frame_tx: three instances (default, SHIFT=4, CLK_DIV=1) with a pin-level
// frame monitor that checks every decoded frame against a queue of expected words.
module tb_dac_frame_tx;
  localparam int N = 23;

  typedef struct {
    int          inst;
    logic [15:0] word;
    logic        sat;
    int          cd;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  logic [2:0]   start_r;
  logic [N-1:0] data_r [3];

  dac_frame_tx_if #(.N(N)) if0 ();
  dac_frame_tx_if #(.N(N)) if1 ();
  dac_frame_tx_if #(.N(N)) if2 ();

  assign if0.start = start_r[0];
  assign if1.start = start_r[1];
  assign if2.start = start_r[2];
  assign if0.data_in = data_r[0];
  assign if1.data_in = data_r[1];
  assign if2.data_in = data_r[2];

  dac_frame_tx #(.N(N), .SHIFT(0), .CLK_DIV(4)) u0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  dac_frame_tx #(.N(N), .SHIFT(4), .CLK_DIV(4)) u1 (.clk(clk), .reset_n(reset_n), .bus(if1));
  dac_frame_tx #(.N(N), .SHIFT(0), .CLK_DIV(1)) u2 (.clk(clk), .reset_n(reset_n), .bus(if2));

  logic [2:0] busy_a, done_a, sat_a, sclk_a, sync_a, sdata_a;
  assign busy_a  = {if2.busy,   if1.busy,   if0.busy};
  assign done_a  = {if2.done,   if1.done,   if0.done};
  assign sat_a   = {if2.sat,    if1.sat,    if0.sat};
  assign sclk_a  = {if2.sclk,   if1.sclk,   if0.sclk};
  assign sync_a  = {if2.sync_n, if1.sync_n, if0.sync_n};
  assign sdata_a = {if2.sdata,  if1.sdata,  if0.sdata};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame monitor: decode bits on sclk falling edges while sync_n is low.
  logic [2:0]  prev_sclk, prev_sync, prev_sdata;
  logic [15:0] mword [3];
  int          nfall [3];
  int          nlow  [3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        nfall[i] = 0;
        nlow[i]  = 0;
        mword[i] = '0;
      end else if (!sync_a[i]) begin
        nlow[i]++;
        if (prev_sclk[i] && !sclk_a[i]) begin
          checks++;
          if (sdata_a[i] !== prev_sdata[i]) begin
            errors++;
            $display("FAIL sdata_fall inst%0d cyc%0d: got %b, required %b", i, cyc, sdata_a[i], prev_sdata[i]);
          end
          mword[i] = {mword[i][14:0], sdata_a[i]};
          nfall[i]++;
        end
        if (!prev_sync[i] && (sdata_a[i] !== prev_sdata[i]) && !(sclk_a[i] && !prev_sclk[i])) begin
          errors++;
          $display("FAIL sdata_change inst%0d cyc%0d: sdata moved outside an sclk rising edge", i, cyc);
        end
      end else if (!prev_sync[i]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_empty inst%0d: frame 0x%04h seen, none expected", i, mword[i]);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.inst != i || mword[i] !== e.word || nfall[i] != 16 || nlow[i] != 32 * e.cd
              || done_a[i] !== 1'b1 || sat_a[i] !== e.sat) begin
            errors++;
            $display("FAIL frame inst%0d: got word 0x%04h falls %0d low %0d done %b sat %b, required inst%0d word 0x%04h falls 16 low %0d done 1 sat %b",
                     i, mword[i], nfall[i], nlow[i], done_a[i], sat_a[i], e.inst, e.word, 32 * e.cd, e.sat);
          end
        end
        nfall[i] = 0;
        nlow[i]  = 0;
        mword[i] = '0;
      end
      prev_sclk[i]  = sclk_a[i];
      prev_sync[i]  = sync_a[i];
      prev_sdata[i] = sdata_a[i];
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic run_frame(input int inst, input int d, input logic [15:0] w, input logic s, input int cd);
    int t0;
    bit seen;
    exp_t e;
    e.inst = inst; e.word = w; e.sat = s; e.cd = cd;
    sb.push_back(e);
    @(negedge clk);
    start_r[inst] = 1'b1;
    data_r[inst]  = N'(d);
    t0 = cyc;
    @(negedge clk);
    start_r[inst] = 1'b0;
    data_r[inst]  = N'($urandom);
    checks++;
    if (sync_a[inst] !== 1'b0 || sclk_a[inst] !== 1'b1 || busy_a[inst] !== 1'b1
        || sdata_a[inst] !== w[15] || sat_a[inst] !== s) begin
      errors++;
      $display("FAIL first_cycle inst%0d: got sync_n %b sclk %b busy %b sdata %b sat %b, required 0 1 1 %b %b",
               inst, sync_a[inst], sclk_a[inst], busy_a[inst], sdata_a[inst], sat_a[inst], w[15], s);
    end
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (done_a[inst]) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout inst%0d: no done within 300 cycles", inst);
    end else if (cyc != t0 + 1 + 32 * cd) begin
      errors++;
      $display("FAIL done_time inst%0d: got T+%0d, required T+%0d", inst, cyc - t0, 1 + 32 * cd);
    end
    @(negedge clk);
    checks++;
    if (busy_a[inst] !== 1'b0 || done_a[inst] !== 1'b0 || sat_a[inst] !== s) begin
      errors++;
      $display("FAIL after_done inst%0d: got busy %b done %b sat %b, required 0 0 %b",
               inst, busy_a[inst], done_a[inst], sat_a[inst], s);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start_r = '0;
    for (int i = 0; i < 3; i++) data_r[i] = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (sclk_a !== 3'b111 || sync_a !== 3'b111 || sdata_a !== 3'b000 || busy_a !== 3'b000
        || done_a !== 3'b000 || sat_a !== 3'b000) begin
      errors++;
      $display("FAIL reset: got sclk %b sync_n %b sdata %b busy %b done %b sat %b, required 111 111 000 000 000 000",
               sclk_a, sync_a, sdata_a, busy_a, done_a, sat_a);
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero;
    run_frame(0, 0, 16'h0800, 1'b0, 4);
  endtask

  task automatic test_saturation;
    run_frame(0, -1,    16'h07FF, 1'b0, 4);
    run_frame(0, 5000,  16'h0FFF, 1'b1, 4);
    run_frame(0, -5000, 16'h0000, 1'b1, 4);
  endtask

  task automatic test_shift;
    run_frame(1, 256, 16'h0810, 1'b0, 4);
  endtask

  task automatic test_reset_mid;
    int t0;
    bit bad;
    @(negedge clk);
    start_r[0] = 1'b1;
    data_r[0]  = N'(32'h100);
    t0 = cyc;
    @(negedge clk);
    start_r[0] = 1'b0;
    wait_until(t0 + 40);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (if0.sync_n !== 1'b1 || if0.sclk !== 1'b1 || if0.busy !== 1'b0 || if0.done !== 1'b0 || if0.sat !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got sync_n %b sclk %b busy %b done %b sat %b, required 1 1 0 0 0",
               if0.sync_n, if0.sclk, if0.busy, if0.done, if0.sat);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bad = 1'b0;
    repeat (140) begin
      @(negedge clk);
      if (if0.done !== 1'b0 || if0.busy !== 1'b0 || if0.sync_n !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_resume: got activity after abort, required idle");
    end
    run_frame(0, 32'h100, 16'h0900, 1'b0, 4);
  endtask

  task automatic test_start_held;
    int t0;
    bit seen;
    exp_t e;
    e.inst = 0; e.word = 16'h0900; e.sat = 1'b0; e.cd = 4;
    sb.push_back(e);
    e.word = 16'h0800;
    sb.push_back(e);
    @(negedge clk);
    start_r[0] = 1'b1;
    data_r[0]  = N'(32'h100);
    t0 = cyc;
    wait_until(t0 + 40);
    data_r[0] = '0;
    wait_until(t0 + 129);
    checks++;
    if (if0.done !== 1'b1 || if0.sync_n !== 1'b1) begin
      errors++;
      $display("FAIL held_done: got done %b sync_n %b at T+129, required 1 1", if0.done, if0.sync_n);
    end
    @(negedge clk);
    checks++;
    if (if0.busy !== 1'b0) begin
      errors++;
      $display("FAIL held_idle: got busy %b at T+130, required 0", if0.busy);
    end
    @(negedge clk);
    start_r[0] = 1'b0;
    checks++;
    if (if0.busy !== 1'b1 || if0.sync_n !== 1'b0 || if0.sclk !== 1'b1) begin
      errors++;
      $display("FAIL held_reaccept: got busy %b sync_n %b sclk %b at T+131, required 1 0 1",
               if0.busy, if0.sync_n, if0.sclk);
    end
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      if (if0.done) seen = 1'b1;
    end
    checks++;
    if (!seen || cyc != t0 + 259) begin
      errors++;
      $display("FAIL held_second_done: got seen %b at T+%0d, required T+259", seen, cyc - t0);
    end
    @(negedge clk);
  endtask

  task automatic test_clk_div1;
    run_frame(2, 2047, 16'h0FFF, 1'b0, 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    prev_sclk = '1; prev_sync = '1; prev_sdata = '0;
    test_reset();
    test_zero();
    test_saturation();
    test_shift();
    test_reset_mid();
    test_start_held();
    test_clk_div1();
    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d frames still expected, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
